// File: rtl/lut_gate_seq.sv
`default_nettype none
// ============================================================================
// Module   : lut_gate_seq
// Brief    : Runtime-programmable N-input truth-table gate. The table loads
//            over a valid/ready config port in MSB-first beats and becomes
//            active atomically. The output is registered and settle-filtered
//            to model gate response delay.
// Revision : 1.0 - initial release
// ============================================================================
module lut_gate_seq #(
  parameter int                    N_IN     = 3,
  parameter int                    CFG_W    = 4,
  parameter int                    SETTLE   = 2,
  parameter logic [(2**N_IN)-1:0]  RESET_TT = 8'hBB
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   in_bits,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CFG_W-1:0]  cfg_data,
  input  logic              cfg_last,
  output logic              cfg_err,
  output logic              busy,
  output logic              out,
  output logic              out_valid
);

  localparam int TT_W  = 2**N_IN;
  localparam int BEATS = TT_W / CFG_W;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(SETTLE + 1);

  localparam logic [CW-1:0] C_SETTLE    = CW'(SETTLE);
  localparam logic [CW-1:0] C_SETTLE_M1 = CW'(SETTLE - 1);
  localparam logic [CW-1:0] C_CNT_ONE   = CW'(1);
  localparam logic [KW-1:0] C_K_LAST    = KW'(BEATS - 1);
  localparam logic [KW-1:0] C_K_ONE     = KW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [TT_W-1:0]   shadow_q, shadow_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic              err_q, err_d;

  logic [N_IN-1:0]   in_q;
  logic              cand_q, cand_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              out_q, out_d;

  logic              w_accept;
  logic              w_final;
  logic [N_IN-1:0]   w_bit_sel;
  logic              w_raw;

  assign cfg_ready = (state_q != S_COMMIT);
  assign busy      = (state_q != S_IDLE);
  assign cfg_err   = err_q;
  assign out       = out_q;
  assign out_valid = (cnt_q == C_SETTLE);

  assign w_accept  = cfg_valid & cfg_ready;
  assign w_final   = (k_q == C_K_LAST);

  // Row 0 maps to the table MSB, so the bit position is the inverted row index.
  assign w_bit_sel = ~in_q;
  assign w_raw     = tt_q[w_bit_sel];

  // Config FSM: collect beats into the shadow table, commit or discard it.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    shadow_d = shadow_q;
    tt_d     = tt_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (w_accept) begin
          for (int b = 0; b < BEATS; b++) begin
            if (k_q == KW'(b)) begin
              shadow_d[TT_W-1-b*CFG_W -: CFG_W] = cfg_data;
            end
          end
          if (w_final && cfg_last) begin
            state_d = S_COMMIT;
            k_d     = '0;
          end else if (w_final || cfg_last) begin
            // Final beat without last, or last arriving early: drop the load.
            err_d    = 1'b1;
            shadow_d = '0;
            k_d      = '0;
            state_d  = S_IDLE;
          end else begin
            k_d     = k_q + C_K_ONE;
            state_d = S_LOAD;
          end
        end
      end
      S_COMMIT: begin
        tt_d    = shadow_q;
        k_d     = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
    endcase
  end

  // Config state, beat index, shadow/active tables and error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      shadow_q <= '0;
      tt_q     <= RESET_TT;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      shadow_q <= shadow_d;
      tt_q     <= tt_d;
      err_q    <= err_d;
    end
  end

  // Settle filter: out follows the candidate only after it has held SETTLE cycles.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    if (w_raw != cand_q) begin
      cand_d = w_raw;
      cnt_d  = '0;
    end else if (cnt_q != C_SETTLE) begin
      cnt_d = cnt_q + C_CNT_ONE;
      if (cnt_q == C_SETTLE_M1) begin
        out_d = cand_q;
      end
    end
    // A new table forces a fresh settle; out keeps its old value meanwhile.
    if (state_q == S_COMMIT) begin
      cnt_d = '0;
    end
  end

  // Input register and settle-filter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q   <= '0;
      cand_q <= RESET_TT[TT_W-1];
      cnt_q  <= C_SETTLE;
      out_q  <= RESET_TT[TT_W-1];
    end else begin
      in_q   <= in_bits;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lut_gate_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_gate_seq
// Brief    : Directed bench for lut_gate_seq: reset state, settle latency,
//            glitch filtering, table loads, malformed loads, mid-load reset,
//            and a 4-input / SETTLE=1 instance swept against a table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lut_gate_seq;

  logic        clk;
  logic        rst_n;

  // Default instance: N_IN=3, CFG_W=4, SETTLE=2, RESET_TT=0xBB
  logic [2:0]  in_a;
  logic        cv_a, cr_a, cl_a, ce_a, busy_a, out_a, ov_a;
  logic [3:0]  cd_a;

  // Wide instance: N_IN=4, CFG_W=8, SETTLE=1
  logic [3:0]  in_b;
  logic        cv_b, cr_b, cl_b, ce_b, busy_b, out_b, ov_b;
  logic [7:0]  cd_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  lut_gate_seq #(.N_IN(3), .CFG_W(4), .SETTLE(2), .RESET_TT(8'hBB)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_bits(in_a),
    .cfg_valid(cv_a), .cfg_ready(cr_a), .cfg_data(cd_a), .cfg_last(cl_a),
    .cfg_err(ce_a), .busy(busy_a), .out(out_a), .out_valid(ov_a)
  );

  lut_gate_seq #(.N_IN(4), .CFG_W(8), .SETTLE(1), .RESET_TT(16'hBBBB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_bits(in_b),
    .cfg_valid(cv_b), .cfg_ready(cr_b), .cfg_data(cd_b), .cfg_last(cl_b),
    .cfg_err(ce_b), .busy(busy_b), .out(out_b), .out_valid(ov_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then step 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    in_a = 3'b000; cv_a = 1'b0; cd_a = 4'h0; cl_a = 1'b0;
    in_b = 4'h0;   cv_b = 1'b0; cd_b = 8'h00; cl_b = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++; if (out_a !== 1'b1) $display("FAIL reset_out: got %b expected 1", out_a); else pass_cnt++;
    total_cnt++; if (ov_a !== 1'b1) $display("FAIL reset_out_valid: got %b expected 1", ov_a); else pass_cnt++;
    total_cnt++; if ({busy_a, cr_a, ce_a} !== 3'b010) $display("FAIL reset_cfg: busy/ready/err got %b expected 010", {busy_a, cr_a, ce_a}); else pass_cnt++;
    // 000 -> 001: 0xBB row1 is 0, reaching out exactly 4 edges later
    in_a = 3'b001;
    tick(1);
    total_cnt++; if ({out_a, ov_a} !== 2'b11) $display("FAIL lat_e1: out/ov got %b expected 11", {out_a, ov_a}); else pass_cnt++;
    tick(1);
    total_cnt++; if ({out_a, ov_a} !== 2'b10) $display("FAIL lat_e2: out/ov got %b expected 10", {out_a, ov_a}); else pass_cnt++;
    tick(1);
    total_cnt++; if ({out_a, ov_a} !== 2'b10) $display("FAIL lat_e3: out/ov got %b expected 10", {out_a, ov_a}); else pass_cnt++;
    tick(1);
    total_cnt++; if ({out_a, ov_a} !== 2'b01) $display("FAIL lat_e4: out/ov got %b expected 01", {out_a, ov_a}); else pass_cnt++;
  endtask

  task automatic test_glitch();
    in_a = 3'b000;
    tick(5);
    total_cnt++; if ({out_a, ov_a} !== 2'b11) $display("FAIL glitch_pre: out/ov got %b expected 11", {out_a, ov_a}); else pass_cnt++;
    in_a = 3'b001;
    tick(1);
    in_a = 3'b000;
    tick(1);
    total_cnt++; if ({out_a, ov_a} !== 2'b10) $display("FAIL glitch_dip: out/ov got %b expected 10", {out_a, ov_a}); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      total_cnt++; if (out_a !== 1'b1) $display("FAIL glitch_hold%0d: got %b expected 1", i, out_a); else pass_cnt++;
    end
    total_cnt++; if (ov_a !== 1'b1) $display("FAIL glitch_recover: out_valid got %b expected 1", ov_a); else pass_cnt++;
  endtask

  task automatic test_load();
    logic [2:0] rows [4];
    logic       exp  [4];
    rows = '{3'b011, 3'b111, 3'b001, 3'b101};
    exp  = '{1'b1,   1'b0,   1'b0,   1'b1};   // rows of 0x96
    cv_a = 1'b1; cd_a = 4'h9; cl_a = 1'b0;
    tick(1);
    total_cnt++; if ({busy_a, cr_a} !== 2'b11) $display("FAIL load_beat0: busy/ready got %b expected 11", {busy_a, cr_a}); else pass_cnt++;
    cd_a = 4'h6; cl_a = 1'b1;
    tick(1);
    cv_a = 1'b0; cl_a = 1'b0;
    total_cnt++; if ({busy_a, cr_a} !== 2'b10) $display("FAIL load_commit: busy/ready got %b expected 10", {busy_a, cr_a}); else pass_cnt++;
    tick(1);
    total_cnt++; if ({busy_a, cr_a, ce_a} !== 3'b010) $display("FAIL load_idle: busy/ready/err got %b expected 010", {busy_a, cr_a, ce_a}); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      in_a = rows[i];
      tick(4);
      total_cnt++; if (out_a !== exp[i]) $display("FAIL load_row%0d: got %b expected %b", rows[i], out_a, exp[i]); else pass_cnt++;
    end
  endtask

  task automatic test_bad_last();
    apply_reset();
    cv_a = 1'b1; cd_a = 4'h9; cl_a = 1'b1;
    tick(1);
    cv_a = 1'b0; cl_a = 1'b0;
    total_cnt++; if ({ce_a, busy_a} !== 2'b10) $display("FAIL err_pulse: err/busy got %b expected 10", {ce_a, busy_a}); else pass_cnt++;
    tick(1);
    total_cnt++; if (ce_a !== 1'b0) $display("FAIL err_clear: got %b expected 0", ce_a); else pass_cnt++;
    in_a = 3'b001;
    tick(4);
    total_cnt++; if (out_a !== 1'b0) $display("FAIL err_row1: got %b expected 0", out_a); else pass_cnt++;
    in_a = 3'b101;
    tick(4);
    total_cnt++; if (out_a !== 1'b0) $display("FAIL err_row5: got %b expected 0", out_a); else pass_cnt++;
    // Final beat without last is also malformed.
    cv_a = 1'b1; cd_a = 4'h9; cl_a = 1'b0;
    tick(1);
    cd_a = 4'h6;
    tick(1);
    cv_a = 1'b0;
    total_cnt++; if ({ce_a, busy_a} !== 2'b10) $display("FAIL err_nolast: err/busy got %b expected 10", {ce_a, busy_a}); else pass_cnt++;
    in_a = 3'b111;
    tick(4);
    total_cnt++; if (out_a !== 1'b1) $display("FAIL err_nolast_row7: got %b expected 1", out_a); else pass_cnt++;
  endtask

  task automatic test_midload_reset();
    apply_reset();
    cv_a = 1'b1; cd_a = 4'h9; cl_a = 1'b0;
    tick(1);
    cv_a = 1'b0;
    tick(3);
    total_cnt++; if (busy_a !== 1'b1) $display("FAIL midload_busy: got %b expected 1", busy_a); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if ({busy_a, cr_a, out_a, ov_a} !== 4'b0111) $display("FAIL midload_async: busy/ready/out/ov got %b expected 0111", {busy_a, cr_a, out_a, ov_a}); else pass_cnt++;
    tick(1);
    rst_n = 1'b1;
    in_a = 3'b111;
    tick(4);
    total_cnt++; if (out_a !== 1'b1) $display("FAIL midload_tt_row7: got %b expected 1", out_a); else pass_cnt++;
    cv_a = 1'b1; cd_a = 4'h9; cl_a = 1'b0;
    tick(1);
    cd_a = 4'h6; cl_a = 1'b1;
    tick(1);
    cv_a = 1'b0; cl_a = 1'b0;
    tick(1);
    total_cnt++; if ({busy_a, ce_a} !== 2'b00) $display("FAIL midload_reload: busy/err got %b expected 00", {busy_a, ce_a}); else pass_cnt++;
    tick(4);
    total_cnt++; if (out_a !== 1'b0) $display("FAIL midload_new_row7: got %b expected 0", out_a); else pass_cnt++;
  endtask

  task automatic test_wide_random();
    logic [15:0] tt;
    logic [3:0]  row;
    for (int t = 0; t < 3; t++) begin
      tt = 16'($urandom());
      if (t == 0) tt = 16'h6A35;
      cv_b = 1'b1; cd_b = tt[15:8]; cl_b = 1'b0;
      tick(1);
      cd_b = tt[7:0]; cl_b = 1'b1;
      tick(1);
      cv_b = 1'b0; cl_b = 1'b0;
      total_cnt++; if (cr_b !== 1'b0) $display("FAIL wide_commit%0d: ready got %b expected 0", t, cr_b); else pass_cnt++;
      tick(1);
      for (int r = 0; r < 16; r++) begin
        row  = 4'(r);
        in_b = row;
        tick(3);
        total_cnt++;
        if ({out_b, ov_b} !== {tt[4'd15 - row], 1'b1})
          $display("FAIL wide_t%0d_row%0d: out/ov got %b%b expected %b1 (tt=%h)", t, r, out_b, ov_b, tt[4'd15 - row], tt);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_load();
    test_bad_last();
    test_midload_reset();
    test_wide_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
